// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder with valid/ready handshake
//
// Computes {Cout,Sum} = A + B + Cin over WIDTH bits using a two-level lookahead
// tree: bit propagate/generate, per-BLOCK group P/G, then group carries across
// blocks. Also exports the whole-word group generate G (independent of Cin) and
// group propagate P so wider adders can be chained from this block.
//
// The arithmetic is evaluated in front of rank 0; STAGES register ranks then
// carry the result to the outputs, each rank with its own valid bit and full
// back-pressure, so latency is exactly STAGES cycles at one op per cycle.
//
// Optional feature macro: CLA_PIPE_OVF_EN adds the signed-overflow output V.
//
// Parameters:
//   WIDTH   operand/sum width, multiple of BLOCK and >= BLOCK
//   BLOCK   lookahead group size in bits (2, 4 or 8)
//   STAGES  pipeline latency in cycles (1..4)
//
// Ports:
//   Clk        clock, rising edge
//   Reset      synchronous active-high reset
//   in_valid   A/B/Cin hold an operation
//   in_ready   adder accepts an operation this cycle (0 while Reset=1)
//   A, B       operands
//   Cin        carry-in
//   out_valid  Sum/Cout/G/P(/V) hold a result
//   out_ready  consumer takes the result this cycle
//   Sum        (A+B+Cin)[WIDTH-1:0]
//   Cout       carry out of bit WIDTH-1
//   G          full-word group generate
//   P          full-word group propagate
//   V          signed overflow (CLA_PIPE_OVF_EN only)

module cla_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             G,
    output logic             P
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int NBLK = WIDTH / BLOCK;

    // Result word carried through the ranks: {[V,] Cout, G, P, Sum}
`ifdef CLA_PIPE_OVF_EN
    localparam int RW = WIDTH + 4;
`else
    localparam int RW = WIDTH + 3;
`endif

    // ------------------------------------------------------------------
    // Lookahead tree
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] g_bit;
    logic [NBLK-1:0]  blk_p;
    logic [NBLK-1:0]  blk_g;
    logic [WIDTH-1:0] sum_d;
    logic             word_g;
    logic             word_p;
    logic             cout_d;
`ifdef CLA_PIPE_OVF_EN
    logic             c_msb;
    logic             v_d;
`endif
    logic [RW-1:0]    res_d;

    assign p_bit = A ^ B;
    assign g_bit = A & B;

    // Per-block group propagate/generate, folded from the LSB of the block up.
    always_comb begin : blk_pg
        logic bp;
        logic bg;
        blk_p = '0;
        blk_g = '0;
        for (int b = 0; b < NBLK; b++) begin
            bp = 1'b1;
            bg = 1'b0;
            for (int i = 0; i < BLOCK; i++) begin
                bg = g_bit[b*BLOCK+i] | (p_bit[b*BLOCK+i] & bg);
                bp = bp & p_bit[b*BLOCK+i];
            end
            blk_p[b] = bp;
            blk_g[b] = bg;
        end
    end

    // Block carries come from the group P/G only; the bit carries inside a
    // block are derived from that block's carry-in. A second chain with a
    // zero carry-in yields the word generate, which must not depend on Cin.
    always_comb begin : carry_sum
        logic blk_c;
        logic bit_c;
        logic gchain;
        sum_d  = '0;
        blk_c  = Cin;
        gchain = 1'b0;
`ifdef CLA_PIPE_OVF_EN
        c_msb  = 1'b0;
`endif
        for (int b = 0; b < NBLK; b++) begin
            bit_c = blk_c;
            for (int i = 0; i < BLOCK; i++) begin
                sum_d[b*BLOCK+i] = p_bit[b*BLOCK+i] ^ bit_c;
`ifdef CLA_PIPE_OVF_EN
                if (b*BLOCK + i == WIDTH - 1) begin
                    c_msb = bit_c;
                end
`endif
                bit_c = g_bit[b*BLOCK+i] | (p_bit[b*BLOCK+i] & bit_c);
            end
            blk_c  = blk_g[b] | (blk_p[b] & blk_c);
            gchain = blk_g[b] | (blk_p[b] & gchain);
        end
        word_g = gchain;
    end

    assign word_p = &blk_p;
    assign cout_d = word_g | (word_p & Cin);

`ifdef CLA_PIPE_OVF_EN
    assign v_d   = c_msb ^ cout_d;
    assign res_d = {v_d, cout_d, word_g, word_p, sum_d};
`else
    assign res_d = {cout_d, word_g, word_p, sum_d};
`endif

    // ------------------------------------------------------------------
    // Pipeline ranks with elastic valid/ready flow control
    // ------------------------------------------------------------------
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [RW-1:0]     res_q [STAGES];

    // A rank may load when it is empty or when its content moves on; the
    // condition ripples back from the output so a full pipe streams freely.
    always_comb begin : advance_chain
        logic a;
        adv = '0;
        a   = !v_q[STAGES-1] || out_ready;
        adv[STAGES-1] = a;
        for (int k = STAGES - 2; k >= 0; k--) begin
            a      = !v_q[k] || a;
            adv[k] = a;
        end
    end

    assign in_ready = adv[0] && !Reset;

    for (genvar k = 0; k < STAGES; k++) begin : g_rank
        logic          v_rank_q;
        logic [RW-1:0] res_rank_q;
        logic          prev_v;
        logic [RW-1:0] prev_res;

        if (k == 0) begin : g_head
            assign prev_v   = in_valid && in_ready;
            assign prev_res = res_d;
        end else begin : g_body
            assign prev_v   = v_q[k-1];
            assign prev_res = res_q[k-1];
        end

        // Data only loads with a valid token, so bubbles never disturb the
        // held result and unqualified operand values never enter the pipe.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                v_rank_q   <= 1'b0;
                res_rank_q <= '0;
            end else if (adv[k]) begin
                v_rank_q <= prev_v;
                if (prev_v) begin
                    res_rank_q <= prev_res;
                end
            end
        end

        assign v_q[k]   = v_rank_q;
        assign res_q[k] = res_rank_q;
    end

    assign out_valid = v_q[STAGES-1];

`ifdef CLA_PIPE_OVF_EN
    assign {V, Cout, G, P, Sum} = res_q[STAGES-1];
`else
    assign {Cout, G, P, Sum} = res_q[STAGES-1];
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder
module tb_cla_pipe_adder;

    localparam int W   = 16;
    localparam int BLK = 4;
    localparam int STG = 2;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         G;
    logic         P;
`ifdef CLA_PIPE_OVF_EN
    logic         V;
`endif

    cla_pipe_adder #(.WIDTH(W), .BLOCK(BLK), .STAGES(STG)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .G         (G),
        .P         (P)
`ifdef CLA_PIPE_OVF_EN
        ,
        .V         (V)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_in     = 0;
    int n_out    = 0;

    // {V, Cout, G, P, Sum}
    typedef logic [W+3:0] exp_t;
    exp_t sb[$];

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] full;
        logic [W:0] gen;
        logic       v;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        gen  = {1'b0, a} + {1'b0, b};
        v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {v, full[W], gen[W], &(a ^ b), full[W-1:0]};
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge Clk) begin : monitor
        exp_t e;
        exp_t act;
        if (Reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_output: got Sum=%h, required no output", Sum);
                end else begin
                    e = sb.pop_front();
`ifdef CLA_PIPE_OVF_EN
                    act = {V, Cout, G, P, Sum};
`else
                    act = {e[W+3], Cout, G, P, Sum};
`endif
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL sb_result: got {V,Cout,G,P,Sum}=%h required %h", act, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(A, B, Cin));
                n_in++;
            end
        end
    end

    task automatic test_reset;
        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        Reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_checks++;
        if ({Cout, G, P, Sum} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got {Cout,G,P,Sum}=%h required 0", {Cout, G, P, Sum});
        end
`ifdef CLA_PIPE_OVF_EN
        n_checks++;
        if (V !== 1'b0) begin n_fail++; $display("FAIL reset_v: got %b required 0", V); end
`endif
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                 input logic [W-1:0] es, input logic ec, input logic eg,
                                 input logic ep, input logic ev);
        int lat;
        @(posedge Clk); #1;
        A = a; B = b; Cin = c; in_valid = 1'b1; out_ready = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_in_ready: got %b required 1", in_ready); end
        @(posedge Clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != STG) begin n_fail++; $display("FAIL dir_latency: got %0d required %0d", lat, STG); end
        n_checks++;
        if ({Sum, Cout, G, P} !== {es, ec, eg, ep}) begin
            n_fail++;
            $display("FAIL dir_result: got Sum=%h Cout=%b G=%b P=%b required Sum=%h Cout=%b G=%b P=%b",
                     Sum, Cout, G, P, es, ec, eg, ep);
        end
`ifdef CLA_PIPE_OVF_EN
        n_checks++;
        if (V !== ev) begin n_fail++; $display("FAIL dir_v: got %b required %b", V, ev); end
`else
        if (ev === 1'bx) $display("note: unexpected unknown overflow expectation");
`endif
        @(posedge Clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_no_dup: got out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        int first;
        int last;
        int cnt;
        int rdy_bad;
        first = -1; last = -1; cnt = 0; rdy_bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 + STG + 4; i++) begin
            @(posedge Clk); #1;
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
            if (i < 8) begin
                A = W'(i); B = W'(2 * i); Cin = (i % 2) == 1; in_valid = 1'b1;
                if (in_ready !== 1'b1) rdy_bad++;
            end else begin
                in_valid = 1'b0;
            end
        end
        n_checks++;
        if (rdy_bad != 0) begin n_fail++; $display("FAIL b2b_in_ready: got %0d stalled cycles required 0", rdy_bad); end
        n_checks++;
        if (cnt != 8) begin n_fail++; $display("FAIL b2b_count: got %0d outputs required 8", cnt); end
        n_checks++;
        if (last - first != 7) begin n_fail++; $display("FAIL b2b_gapless: got span %0d required 7", last - first); end
        n_checks++;
        if (first != STG) begin n_fail++; $display("FAIL b2b_first: got cycle %0d required %0d", first, STG); end
    endtask

    task automatic test_stall;
        int filled;
        int out_before;
        int bad_rdy;
        int bad_hold;
        int waitc;
        logic [W+2:0] snap;
        filled = 0; bad_rdy = 0; bad_hold = 0;
        out_before = n_out;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            A = W'(16'hA5A0 + k); B = W'(16'h0F0F * (k + 1)); Cin = k[0]; in_valid = 1'b1;
            @(negedge Clk);
            if (!in_ready) break;
            filled++;
            @(posedge Clk); #1;
        end
        n_checks++;
        if (filled != STG) begin n_fail++; $display("FAIL stall_fill: got %0d accepted required %0d", filled, STG); end
        snap = {Cout, G, P, Sum};
        @(posedge Clk); #1;
        A = 'x; B = 'x; Cin = 1'bx; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (in_ready !== 1'b0) bad_rdy++;
            if (out_valid !== 1'b1 || {Cout, G, P, Sum} !== snap) bad_hold++;
            @(posedge Clk); #1;
        end
        n_checks++;
        if (bad_rdy != 0) begin n_fail++; $display("FAIL stall_in_ready: got %0d ready cycles required 0", bad_rdy); end
        n_checks++;
        if (bad_hold != 0) begin n_fail++; $display("FAIL stall_hold: got %0d changed cycles required 0", bad_hold); end
        in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
        out_ready = 1'b1;
        waitc = 0;
        while (sb.size() != 0 && waitc < 30) begin @(posedge Clk); #1; waitc++; end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL stall_drain: got %0d pending required 0", sb.size()); end
        n_checks++;
        if (n_out - out_before != filled) begin
            n_fail++; $display("FAIL stall_count: got %0d outputs required %0d", n_out - out_before, filled);
        end
    endtask

    task automatic test_reset_midflight;
        int out_before;
        int seen;
        int waitc;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        A = 16'h1234; B = 16'h1111; Cin = 1'b0; in_valid = 1'b1;
        @(posedge Clk); #1;
        A = 16'h4321; B = 16'h2222; Cin = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0; Reset = 1'b1;
        @(posedge Clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
        Reset = 1'b0; out_ready = 1'b1;
        out_before = n_out;
        seen = 0;
        repeat (6) begin
            @(posedge Clk); #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rstmid_discard: got %0d valid cycles required 0", seen); end
        A = 16'h00FF; B = 16'h0001; Cin = 1'b1; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        waitc = 0;
        while (sb.size() != 0 && waitc < 20) begin @(posedge Clk); #1; waitc++; end
        n_checks++;
        if (n_out - out_before != 1) begin
            n_fail++; $display("FAIL rstmid_post: got %0d outputs required 1", n_out - out_before);
        end
    endtask

    task automatic test_random;
        int in_before;
        int out_before;
        int waitc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        in_before = n_in; out_before = n_out;
        for (int k = 0; k < 3000; k++) begin
            @(posedge Clk); #1;
            ra = W'($urandom); rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: rb = '1;
                2: begin ra = W'(1) << (W - 1); rb = ra; end
                3: rb = ~ra;
                default: ;
            endcase
            A = ra; B = rb; Cin = 1'($urandom_range(0, 1));
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge Clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        waitc = 0;
        while (sb.size() != 0 && waitc < 50) begin @(posedge Clk); #1; waitc++; end
        n_checks++;
        if (n_in - in_before != n_out - out_before) begin
            n_fail++;
            $display("FAIL rand_count: got %0d outputs required %0d", n_out - out_before, n_in - in_before);
        end
        n_checks++;
        if (n_in - in_before < 1000) begin
            n_fail++; $display("FAIL rand_traffic: got %0d transfers required at least 1000", n_in - in_before);
        end
    endtask

    initial begin
        test_reset();
        test_directed(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        test_directed(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        test_directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
